// File: rtl/ysyx_22050039_ifu_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode hand-off,
// redirect input and status outputs. "master" is the IFU side, "slave" its environment.
`timescale 1ns/1ps
interface ysyx_22050039_ifu_if #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32
);
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [XLEN-1:0]     imem_req_addr;
    logic                imem_resp_valid;
    logic [INST_LEN-1:0] imem_resp_data;
    logic                inst_valid;
    logic                inst_ready;
    logic [INST_LEN-1:0] inst;
    logic [XLEN-1:0]     inst_pc;
    logic                redirect_valid;
    logic [XLEN-1:0]     redirect_pc;
    logic                fetch_misalign;
    logic [XLEN-1:0]     fetch_cnt;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
               fetch_misalign, fetch_cnt,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
               fetch_misalign, fetch_cnt,
        output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ysyx_22050039_ifu.sv
// Instruction fetch unit: owns the PC, keeps one fetch outstanding at a time, holds the
// fetched word for decode and discards responses made stale by a redirect.
`timescale 1ns/1ps
module ysyx_22050039_ifu #(
    parameter int              XLEN     = 64,
    parameter int              INST_LEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input logic                 clk,
    input logic                 rst,
    ysyx_22050039_ifu_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP,
        S_HOLD,
        S_HALT
    } state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic [INST_LEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0]     inst_pc_q, inst_pc_d;
    logic                misalign_q, misalign_d;
    logic [XLEN-1:0]     cnt_q, cnt_d;

    logic redir_bad;
    logic redir_ok;
    logic accept;

    assign redir_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    assign redir_ok  = bus.redirect_valid && (bus.redirect_pc[1:0] == 2'b00);
    assign accept    = (state_q == S_HOLD) && bus.inst_ready;

    // Request and hand-off valids come from registered state only (plus redirect for req).
    assign bus.imem_req_valid = (state_q == S_REQ) && !bus.redirect_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = (state_q == S_HOLD);
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.fetch_misalign = misalign_q;
    assign bus.fetch_cnt      = cnt_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        misalign_d = misalign_q;
        cnt_d      = cnt_q;

        if (accept) cnt_d = cnt_q + XLEN'(1);

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  if (bus.imem_req_valid && bus.imem_req_ready) state_d = S_WAIT;
            S_WAIT: if (bus.imem_resp_valid) begin
                inst_d    = bus.imem_resp_data;
                inst_pc_d = pc_q;
                state_d   = S_HOLD;
            end
            S_DROP: if (bus.imem_resp_valid) state_d = S_REQ;
            S_HOLD: if (bus.inst_ready) begin
                pc_d    = pc_q + XLEN'(4);
                state_d = S_REQ;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // Redirect overrides everything above; a same-cycle response is always discarded.
        if (redir_bad) begin
            misalign_d = 1'b1;
            pc_d       = pc_q;
            inst_d     = inst_q;
            inst_pc_d  = inst_pc_q;
            state_d    = S_HALT;
        end else if (redir_ok) begin
            pc_d      = bus.redirect_pc;
            inst_d    = inst_q;
            inst_pc_d = inst_pc_q;
            case (state_q)
                S_REQ:   state_d = S_REQ;
                // The stale word arriving now retires the outstanding fetch; waiting for
                // another response in DROP would never end.
                S_WAIT,
                S_DROP:  state_d = bus.imem_resp_valid ? S_REQ : S_DROP;
                S_HOLD:  state_d = S_REQ;
                default: state_d = state_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            inst_q     <= '0;
            inst_pc_q  <= '0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule
